boot_sequencer: RTL

- Sequences the pipelined processor from power-up to halt.
- Holds the core in reset while a program image streams in over a valid/ready port, writing it word-by-word into instruction memory.
- Then releases the core and watches its data-store port for a store to the tohost address, latching an exit code.
- Sits beside the processor at SoC top level; drives the core's reset and the instruction-memory write port.

---
 rtl/boot_pkg.sv | 17 +
 rtl/boot_watchdog.sv | 32 +++
 rtl/boot_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types for the boot sequencer: FSM state encoding and error codes.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    HALT = 3'd4,
    ERR  = 3'd5
  } boot_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/boot_watchdog.sv
// Loadable down-counter with clear, enable and a terminal-count flag.
// Saturates at zero, so a load value of zero keeps the terminal flag quiet.
module boot_watchdog #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign terminal = (count == WIDTH'(LIMIT));

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: streams a program image into instruction memory with the
// core held in reset, releases the core, and latches the exit code on halt.
//
// state | meaning
// IDLE  | core held in reset, waiting for start
// LOAD  | accepting image words, writing instruction memory
// HOLD  | load complete, core kept in reset while the pipeline flushes
// RUN   | core running, watchdog counting
// HALT  | tohost store seen, exit_code valid
// ERR   | image overflow or watchdog timeout, see err_code
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          HOLD_CYCLES = 4,
  parameter logic [31:0] HALT_ADDR   = 32'h0000_1000,
  parameter logic [31:0] TIMEOUT     = 32'd1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  input  logic [31:0]       core_address,
  input  logic [31:0]       core_write_data,
  input  logic              core_wen,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [31:0]       exit_code,
  output logic [ADDR_W:0]   word_count
);

  localparam int              IMEM_WORDS = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_SLOT  = (ADDR_W + 1)'(IMEM_WORDS - 1);

  boot_state_t state, state_nxt;
  logic        accept, halt_hit, hold_tc, wdog_tc;

  assign ld_ready = (state == LOAD);
  assign accept   = ld_valid && ld_ready;
  assign halt_hit = core_wen && (core_address == HALT_ADDR);

  boot_watchdog #(.WIDTH(8), .LIMIT(1)) u_hold (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_nxt != HOLD),
    .load       ((state != HOLD) && (state_nxt == HOLD)),
    .load_value (8'(HOLD_CYCLES)),
    .enable     (state == HOLD),
    .terminal   (hold_tc)
  );

  // Counts down from TIMEOUT across RUN; equivalent to an up-count reaching TIMEOUT-1.
  boot_watchdog #(.WIDTH(32), .LIMIT(1)) u_wdog (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_nxt != RUN),
    .load       ((state != RUN) && (state_nxt == RUN)),
    .load_value (TIMEOUT),
    .enable     (state == RUN),
    .terminal   (wdog_tc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALT, ERR: if (start) state_nxt = LOAD;
      LOAD: begin
        if (accept) begin
          if (ld_last)                  state_nxt = HOLD;
          else if (word_count == LAST_SLOT) state_nxt = ERR;
        end
      end
      HOLD: if (hold_tc) state_nxt = RUN;
      RUN: begin
        if (halt_hit)     state_nxt = HALT;
        else if (wdog_tc) state_nxt = ERR;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      core_reset <= 1'b1;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      exit_code  <= '0;
      word_count <= '0;
    end else begin
      state      <= state_nxt;
      core_reset <= (state_nxt != RUN);
      busy       <= (state_nxt == LOAD) || (state_nxt == HOLD) || (state_nxt == RUN);
      done       <= (state_nxt == HALT);
      error      <= (state_nxt == ERR);
      imem_we    <= accept && !abort;

      if (accept && !abort) begin
        imem_waddr <= word_count[ADDR_W-1:0];
        imem_wdata <= ld_data;
        word_count <= word_count + (ADDR_W + 1)'(1);
      end

      if ((state != LOAD) && (state_nxt == LOAD)) begin
        word_count <= '0;
        err_code   <= ERR_NONE;
      end
      if ((state == LOAD) && (state_nxt == ERR)) err_code <= ERR_OVERFLOW;
      if ((state == RUN) && (state_nxt == ERR))  err_code <= ERR_TIMEOUT;
      if ((state == RUN) && (state_nxt == HALT)) exit_code <= core_write_data;
    end
  end

endmodule
